// File: rtl/counter_pkg.sv
// rtl/counter_pkg.sv - shared mode constants and terminal-value helper for the counter family
package counter_pkg;

    localparam int MODE_WRAP     = 0;
    localparam int MODE_SATURATE = 1;
    localparam int MODE_RELOAD   = 2;

    // Callers truncate the 64-bit result to their own WIDTH.
    function automatic logic [63:0] terminal_value(input int width, input logic up);
        logic [63:0] all_ones;
        all_ones = (64'd1 << width) - 64'd1;
        return up ? all_ones : 64'd0;
    endfunction

endpackage

// File: rtl/counter_next_calc.sv
// rtl/counter_next_calc.sv - combinational next-count and terminal-step detection
module counter_next_calc
    import counter_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int MODE  = MODE_WRAP
) (
    input  logic [WIDTH-1:0] count,
    input  logic             up,
    input  logic             enable,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic [WIDTH-1:0] reload_reg,
    output logic [WIDTH-1:0] next_count,
    output logic             is_terminal_step
);

    logic [WIDTH-1:0] term;

    always_comb begin
        term             = WIDTH'(terminal_value(WIDTH, up));
        is_terminal_step = 1'b0;
        next_count       = count;
        if (load) begin
            next_count = load_value;
        end else if (enable) begin
            if (count == term) begin
                is_terminal_step = 1'b1;
                // Unknown MODE values fall through to wrap behaviour.
                if (MODE == MODE_SATURATE) begin
                    next_count = count;
                end else if (MODE == MODE_RELOAD) begin
                    next_count = reload_reg;
                end else begin
                    next_count = up ? '0 : '1;
                end
            end else begin
                next_count = up ? count + WIDTH'(1) : count - WIDTH'(1);
            end
        end
    end

endmodule

// File: rtl/updown_counter_param.sv
// rtl/updown_counter_param.sv - parametrised up/down counter with load, tc pulse and sticky overflow
module updown_counter_param
    import counter_pkg::*;
#(
    parameter int               WIDTH       = 16,
    parameter logic [WIDTH-1:0] RESET_VALUE = {WIDTH{1'b1}},
    parameter int               MODE        = MODE_WRAP
) (
    input  logic             clock0,
    input  logic             reset,
    input  logic             enable,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             clear_ovf,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             ovf
);

    logic [WIDTH-1:0] reload_reg;
    logic [WIDTH-1:0] next_count;
    logic             is_terminal_step;

    counter_next_calc #(
        .WIDTH (WIDTH),
        .MODE  (MODE)
    ) u_next (
        .count            (count),
        .up               (up),
        .enable           (enable),
        .load             (load),
        .load_value       (load_value),
        .reload_reg       (reload_reg),
        .next_count       (next_count),
        .is_terminal_step (is_terminal_step)
    );

    always_ff @(posedge clock0 or negedge reset) begin
        if (!reset) begin
            count      <= RESET_VALUE;
            reload_reg <= RESET_VALUE;
            tc         <= 1'b0;
            ovf        <= 1'b0;
        end else begin
            count <= next_count;
            tc    <= is_terminal_step;
            if (load) begin
                reload_reg <= load_value;
            end
            // A terminal step in the same cycle as clear_ovf keeps the flag set.
            if (is_terminal_step) begin
                ovf <= 1'b1;
            end else if (clear_ovf) begin
                ovf <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_updown_counter_param.sv
// tb/tb_updown_counter_param.sv - scoreboard bench across wrap, saturate and reload configurations
module tb_updown_counter_param;

    typedef struct {
        logic [15:0] count;
        logic        tc;
        logic        ovf;
    } exp_t;

    typedef struct {
        logic        ld;
        logic [15:0] lv;
        logic        en;
        logic        up;
        logic        clr;
        logic [15:0] ec;
        logic        et;
        logic        eo;
    } step_t;

    logic clock0 = 1'b0;
    logic reset  = 1'b0;

    logic        en_u, up_u, ld_u, clr_u, tc_u, ovf_u;
    logic [15:0] lv_u, cnt_u;
    logic        en_w, up_w, ld_w, clr_w, tc_w, ovf_w;
    logic [3:0]  lv_w, cnt_w;
    logic        en_s, up_s, ld_s, clr_s, tc_s, ovf_s;
    logic [3:0]  lv_s, cnt_s;
    logic        en_r, up_r, ld_r, clr_r, tc_r, ovf_r;
    logic [7:0]  lv_r, cnt_r;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;

    always #5 clock0 = ~clock0;

    updown_counter_param #(.WIDTH(16), .MODE(0)) dut_u16 (
        .clock0(clock0), .reset(reset), .enable(en_u), .up(up_u), .load(ld_u),
        .load_value(lv_u), .clear_ovf(clr_u), .count(cnt_u), .tc(tc_u), .ovf(ovf_u));
    updown_counter_param #(.WIDTH(4), .MODE(0)) dut_wrap4 (
        .clock0(clock0), .reset(reset), .enable(en_w), .up(up_w), .load(ld_w),
        .load_value(lv_w), .clear_ovf(clr_w), .count(cnt_w), .tc(tc_w), .ovf(ovf_w));
    updown_counter_param #(.WIDTH(4), .MODE(1)) dut_sat4 (
        .clock0(clock0), .reset(reset), .enable(en_s), .up(up_s), .load(ld_s),
        .load_value(lv_s), .clear_ovf(clr_s), .count(cnt_s), .tc(tc_s), .ovf(ovf_s));
    updown_counter_param #(.WIDTH(8), .MODE(2)) dut_rel8 (
        .clock0(clock0), .reset(reset), .enable(en_r), .up(up_r), .load(ld_r),
        .load_value(lv_r), .clear_ovf(clr_r), .count(cnt_r), .tc(tc_r), .ovf(ovf_r));

    function automatic step_t mk(logic ld, logic [15:0] lv, logic en, logic up, logic clr,
                                 logic [15:0] ec, logic et, logic eo);
        step_t s;
        s.ld = ld; s.lv = lv; s.en = en; s.up = up; s.clr = clr;
        s.ec = ec; s.et = et; s.eo = eo;
        return s;
    endfunction

    function automatic exp_t to_exp(step_t s);
        exp_t e;
        e.count = s.ec; e.tc = s.et; e.ovf = s.eo;
        return e;
    endfunction

    task automatic test_reset();
        exp_t e;
        repeat (2) @(posedge clock0);
        #1;
        exp_q.push_back('{count: 16'hFFFF, tc: 1'b0, ovf: 1'b0});
        exp_q.push_back('{count: 16'h00FF, tc: 1'b0, ovf: 1'b0});
        e = exp_q.pop_front();
        checks += 3;
        if (cnt_u !== e.count) begin errors++; $display("FAIL reset_u16_count got %h want %h", cnt_u, e.count); end
        if (tc_u !== e.tc)     begin errors++; $display("FAIL reset_u16_tc got %b want %b", tc_u, e.tc); end
        if (ovf_u !== e.ovf)   begin errors++; $display("FAIL reset_u16_ovf got %b want %b", ovf_u, e.ovf); end
        e = exp_q.pop_front();
        checks++;
        if ({8'h00, cnt_r} !== e.count) begin errors++; $display("FAIL reset_r8_count got %h want %h", cnt_r, e.count); end
        reset = 1'b1;
    endtask

    task automatic test_down_count();
        step_t st[$];
        exp_t  e;
        for (int i = 0; i < 3; i++) st.push_back(mk(0, 0, 1, 0, 0, 16'hFFFE - 16'(i), 0, 0));
        foreach (st[i]) begin
            ld_u = st[i].ld; lv_u = st[i].lv; en_u = st[i].en; up_u = st[i].up; clr_u = st[i].clr;
            exp_q.push_back(to_exp(st[i]));
            @(posedge clock0); #1;
            e = exp_q.pop_front();
            checks += 3;
            if (cnt_u !== e.count) begin errors++; $display("FAIL down_count[%0d] count got %h want %h", i, cnt_u, e.count); end
            if (tc_u !== e.tc)     begin errors++; $display("FAIL down_count[%0d] tc got %b want %b", i, tc_u, e.tc); end
            if (ovf_u !== e.ovf)   begin errors++; $display("FAIL down_count[%0d] ovf got %b want %b", i, ovf_u, e.ovf); end
        end
        en_u = 1'b0;
    endtask

    task automatic test_wrap();
        step_t st[$];
        exp_t  e;
        st.push_back(mk(1, 16'h1, 0, 0, 0, 16'h1, 0, 0));
        st.push_back(mk(0, 0, 1, 0, 0, 16'h0, 0, 0));
        st.push_back(mk(0, 0, 1, 0, 0, 16'hF, 1, 1));
        st.push_back(mk(0, 0, 1, 1, 0, 16'h0, 1, 1));
        st.push_back(mk(0, 0, 1, 1, 0, 16'h1, 0, 1));
        foreach (st[i]) begin
            ld_w = st[i].ld; lv_w = st[i].lv[3:0]; en_w = st[i].en; up_w = st[i].up; clr_w = st[i].clr;
            exp_q.push_back(to_exp(st[i]));
            @(posedge clock0); #1;
            e = exp_q.pop_front();
            checks += 3;
            if ({12'h0, cnt_w} !== e.count) begin errors++; $display("FAIL wrap[%0d] count got %h want %h", i, cnt_w, e.count); end
            if (tc_w !== e.tc)              begin errors++; $display("FAIL wrap[%0d] tc got %b want %b", i, tc_w, e.tc); end
            if (ovf_w !== e.ovf)            begin errors++; $display("FAIL wrap[%0d] ovf got %b want %b", i, ovf_w, e.ovf); end
        end
        en_w = 1'b0; ld_w = 1'b0;
    endtask

    task automatic test_saturate();
        step_t st[$];
        exp_t  e;
        st.push_back(mk(1, 16'hE, 0, 1, 0, 16'hE, 0, 0));
        st.push_back(mk(0, 0, 1, 1, 0, 16'hF, 0, 0));
        st.push_back(mk(0, 0, 1, 1, 0, 16'hF, 1, 1));
        st.push_back(mk(0, 0, 1, 1, 1, 16'hF, 1, 1));
        st.push_back(mk(0, 0, 0, 1, 1, 16'hF, 0, 0));
        st.push_back(mk(0, 0, 0, 1, 0, 16'hF, 0, 0));
        foreach (st[i]) begin
            ld_s = st[i].ld; lv_s = st[i].lv[3:0]; en_s = st[i].en; up_s = st[i].up; clr_s = st[i].clr;
            exp_q.push_back(to_exp(st[i]));
            @(posedge clock0); #1;
            e = exp_q.pop_front();
            checks += 3;
            if ({12'h0, cnt_s} !== e.count) begin errors++; $display("FAIL saturate[%0d] count got %h want %h", i, cnt_s, e.count); end
            if (tc_s !== e.tc)              begin errors++; $display("FAIL saturate[%0d] tc got %b want %b", i, tc_s, e.tc); end
            if (ovf_s !== e.ovf)            begin errors++; $display("FAIL saturate[%0d] ovf got %b want %b", i, ovf_s, e.ovf); end
        end
    endtask

    task automatic run_r8(input string name, input step_t st[$]);
        exp_t e;
        foreach (st[i]) begin
            ld_r = st[i].ld; lv_r = st[i].lv[7:0]; en_r = st[i].en; up_r = st[i].up; clr_r = st[i].clr;
            exp_q.push_back(to_exp(st[i]));
            @(posedge clock0); #1;
            e = exp_q.pop_front();
            checks += 3;
            if ({8'h0, cnt_r} !== e.count) begin errors++; $display("FAIL %s[%0d] count got %h want %h", name, i, cnt_r, e.count); end
            if (tc_r !== e.tc)             begin errors++; $display("FAIL %s[%0d] tc got %b want %b", name, i, tc_r, e.tc); end
            if (ovf_r !== e.ovf)           begin errors++; $display("FAIL %s[%0d] ovf got %b want %b", name, i, ovf_r, e.ovf); end
        end
    endtask

    task automatic test_reload();
        step_t st[$];
        st.push_back(mk(1, 16'h03, 0, 0, 0, 16'h03, 0, 0));
        st.push_back(mk(0, 0, 1, 0, 0, 16'h02, 0, 0));
        st.push_back(mk(0, 0, 1, 0, 0, 16'h01, 0, 0));
        st.push_back(mk(0, 0, 1, 0, 0, 16'h00, 0, 0));
        st.push_back(mk(0, 0, 1, 0, 0, 16'h03, 1, 1));
        st.push_back(mk(0, 0, 1, 0, 0, 16'h02, 0, 1));
        run_r8("reload", st);
    endtask

    task automatic test_priority_hold();
        step_t st[$];
        st.push_back(mk(1, 16'h55, 1, 0, 0, 16'h55, 0, 1));
        for (int i = 0; i < 5; i++) st.push_back(mk(0, 16'hAA, 0, i[0], 0, 16'h55, 0, 1));
        run_r8("priority_hold", st);
    endtask

    task automatic test_async_reset();
        step_t st[$];
        exp_t  e;
        st.push_back(mk(1, 16'h12, 0, 0, 0, 16'h12, 0, 1));
        run_r8("pre_async", st);
        ld_r = 1'b0;
        #2 reset = 1'b0;
        exp_q.push_back('{count: 16'h00FF, tc: 1'b0, ovf: 1'b0});
        #1;
        e = exp_q.pop_front();
        checks += 3;
        if ({8'h0, cnt_r} !== e.count) begin errors++; $display("FAIL async_reset count got %h want %h", cnt_r, e.count); end
        if (tc_r !== e.tc)             begin errors++; $display("FAIL async_reset tc got %b want %b", tc_r, e.tc); end
        if (ovf_r !== e.ovf)           begin errors++; $display("FAIL async_reset ovf got %b want %b", ovf_r, e.ovf); end
        #1 reset = 1'b1;
        st.delete();
        st.push_back(mk(0, 0, 1, 0, 0, 16'hFE, 0, 0));
        run_r8("post_async", st);
    endtask

    initial begin
        {en_u, up_u, ld_u, clr_u} = '0; lv_u = '0;
        {en_w, up_w, ld_w, clr_w} = '0; lv_w = '0;
        {en_s, up_s, ld_s, clr_s} = '0; lv_s = '0;
        {en_r, up_r, ld_r, clr_r} = '0; lv_r = '0;
        test_reset();
        test_down_count();
        test_wrap();
        test_saturate();
        test_reload();
        test_priority_hold();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired before bench completion");
        errors++;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/updown_counter_param.md
# updown_counter_param

Parametrised successor of the team's fixed 16-bit down counters. It is an up/down counter with configurable width, reset value and end-of-range behaviour, plus:
- a synchronous parallel load that also sets the reload value;
- a registered terminal-count pulse;
- a sticky overflow flag.

It sits in the simple_registers/counters family and is the building block for timers and prescalers.

## Interface
Parameters:
- WIDTH, 16: counter width in bits, at least 2.
- RESET_VALUE, {WIDTH{1'b1}}: value loaded into count and reload_reg on reset.
- MODE, 0: end-of-range behaviour.
  - 0 = WRAP
  - 1 = SATURATE
  - 2 = RELOAD
  - Other values are illegal; the implementation treats them as WRAP.

Ports:
- clock0  input  1  single clock; all state changes on its rising edge.
- reset  input  1  asynchronous, active-low reset. Assertion acts immediately; deassertion takes effect at the next rising edge of clock0.
- enable  input  1  count one step this cycle.
- up  input  1  direction: 1 = increment, 0 = decrement.
- load  input  1  synchronous parallel load.
- load_value  input  WIDTH  value for load.
- clear_ovf  input  1  synchronous clear of ovf.
- count  output  WIDTH  registered counter value.
- tc  output  1  registered terminal-count pulse.
- ovf  output  1  sticky overflow flag.

## Operation
- Reset (reset = 0):
  - count = RESET_VALUE, reload_reg = RESET_VALUE.
  - tc = 0, ovf = 0.
- Terminal value:
  - is 0 when up = 0;
  - is {WIDTH{1'b1}} when up = 1.
  - A terminal step is an enabled step taken while count equals the terminal value for the current direction.
- Priority each cycle is load > enable > hold.
  - load = 1: count ← load_value and reload_reg ← load_value. enable is ignored, tc ← 0.
  - enable = 1, not a terminal step: count ← count ± 1, computed modulo 2^WIDTH.
  - enable = 1, terminal step:
    - WRAP: count ← 0 going up, or all-ones going down.
    - SATURATE: count holds.
    - RELOAD: count ← reload_reg, in either direction.
  - enable = 0: count holds.
- tc ← 1 for exactly one cycle after each terminal step, else 0. Consecutive terminal steps (for example SATURATE with enable held) give tc = 1 in every such cycle.
- ovf:
  - set to 1 on any terminal step and stays set;
  - clear_ovf = 1 clears it;
  - if a terminal step and clear_ovf fall in the same cycle, the set wins and ovf = 1.
- up may change on any cycle. Direction and terminal detection use the value of up in the current cycle only.
- count, tc and ovf are outputs of registers; no combinational path runs from inputs to outputs.

## Timing
- Latency is one cycle: inputs sampled at edge N appear on count, tc and ovf after edge N.
- Load takes effect at the next edge. Counting resumes from load_value on the following enabled edge.
- tc is high in the same cycle that count shows the post-terminal value: 0 or all-ones for WRAP, the held value for SATURATE, reload_reg for RELOAD.
- Reset in mid-operation clears tc and ovf asynchronously. The first edge after reset deasserts operates from RESET_VALUE.
- There is no handshake; enable is a level qualifier sampled every cycle.

## Structure
- Shared package counter_pkg holds:
  - the mode constants MODE_WRAP = 0, MODE_SATURATE = 1, MODE_RELOAD = 2;
  - a function returning the terminal value for a given WIDTH and direction.
- Optional sub-module counter_next_calc: purely combinational.
  - Inputs: count, up, enable, load, load_value, reload_reg.
  - Outputs: next_count and is_terminal_step.
  - The top level keeps all registers and the async-reset always block.

## Test plan
- Reset and basic down count (WIDTH = 16, MODE = 0): release reset, enable = 1, up = 0 for 3 cycles → count FFFF, FFFE, FFFD, FFFC; tc = 0, ovf = 0.
- Wrap in both directions (WIDTH = 4, MODE = 0):
  - load 1, count down with enable → 1, 0, F; tc = 1 only in the cycle showing F; ovf = 1.
  - switch to up → 0 with tc = 1.
- Saturate (WIDTH = 4, MODE = 1): load E, count up for 4 cycles → E, F, F, F; tc = 1 in each of the last two cycles; ovf stays 1 through a clear_ovf pulse that coincides with a terminal step, and clears on a pulse without one.
- Reload (WIDTH = 8, MODE = 2): load 03, down-count 6 cycles → 03, 02, 01, 00, 03, 02; tc = 1 in the cycle showing the second 03.
- Priority and hold:
  - load = 1 with enable = 1 and load_value = 0x55 → count 0x55, tc = 0.
  - enable = 0 for 5 cycles → count stays 0x55.
- Asynchronous reset mid-count: assert reset between edges while count = 0x12 and ovf = 1 → count = RESET_VALUE, tc = 0, ovf = 0 immediately, without waiting for clock0. After release the next down step gives RESET_VALUE − 1.
